// File: rtl/nes_pad_responder.sv
// nes_pad_responder
//   Pad-side emulation of the 4021 shift register found in an NES joypad.
//   The host-driven latch/nes_clk pins are synchronized and deglitched.
//   While latch is high the eight button states are loaded every cycle.
//   After latch falls, each accepted nes_clk rising edge shifts the next
//   bit onto data.
//
//   Ports
//     clk, reset_n      system clock, asynchronous active-low reset
//     latch, nes_clk    host pins, asynchronous to clk
//     A..right          button states (clk domain, 1 = pressed)
//     data              serial output, registered, 0 = pressed
//     frame_strobe      one-cycle pulse when the state leaves LOAD
//     bit_idx           shifts since the last load, saturates at 8

// Per-pin input conditioning: 2-FF synchronizer plus a stability filter.
// The filtered level only moves once the synchronized value has disagreed
// with it for FILTER_LEN consecutive cycles. A binary signal that changes
// while disagreeing must return to agreement, which resets the count.
// This makes the block equivalent to "reset on any change".
module nes_pad_pin_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin,
    output logic lvl
);
    localparam logic [3:0] FILT_CNT = 4'(FILTER_LEN);

    logic [1:0] sync_q, sync_d;
    logic [3:0] cnt_q, cnt_d;
    logic       lvl_q, lvl_d;
    logic [3:0] cnt_inc;

    always_comb begin
        sync_d  = {sync_q[0], pin};
        cnt_d   = '0;
        lvl_d   = lvl_q;
        cnt_inc = cnt_q + 4'd1;
        if (sync_q[1] != lvl_q) begin
            if (cnt_inc == FILT_CNT) begin
                lvl_d = sync_q[1];
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
            lvl_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            lvl_q  <= lvl_d;
        end
    end

    assign lvl = lvl_q;
endmodule

module nes_pad_responder #(
    parameter int FILTER_LEN = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       latch,
    input  logic       nes_clk,
    input  logic       A,
    input  logic       B,
    input  logic       select,
    input  logic       start,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    output logic       data,
    output logic       frame_strobe,
    output logic [3:0] bit_idx
);
    localparam int NUM_PINS = 2;
    localparam int PIN_NES  = 0;
    localparam int PIN_LAT  = 1;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    logic [NUM_PINS-1:0] pin_raw;
    logic [NUM_PINS-1:0] pin_lvl;
    logic [NUM_PINS-1:0] lvl_prev_q, lvl_prev_d;

    assign pin_raw = {latch, nes_clk};

    for (genvar p = 0; p < NUM_PINS; p++) begin : g_pin
        nes_pad_pin_filter #(
            .FILTER_LEN (FILTER_LEN)
        ) u_flt (
            .clk     (clk),
            .reset_n (reset_n),
            .pin     (pin_raw[p]),
            .lvl     (pin_lvl[p])
        );
    end

    // Edge detect on the filtered levels.
    logic nes_rise, latch_rise, latch_fall;
    assign lvl_prev_d = pin_lvl;
    assign nes_rise   =  pin_lvl[PIN_NES] & ~lvl_prev_q[PIN_NES];
    assign latch_rise =  pin_lvl[PIN_LAT] & ~lvl_prev_q[PIN_LAT];
    assign latch_fall = ~pin_lvl[PIN_LAT] &  lvl_prev_q[PIN_LAT];

    // A sits in bit 0 so it is on data as soon as the load happens.
    logic [7:0] load_word;
    assign load_word = ~{right, left, down, up, start, select, B, A};

    state_t     state_q, state_d;
    logic [7:0] sr_q, sr_d;
    logic [3:0] bit_idx_q, bit_idx_d;
    logic       strobe_q, strobe_d;

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        bit_idx_d = bit_idx_q;
        strobe_d  = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (latch_fall) begin
                    // The frame freezes on the word loaded last cycle.
                    state_d  = ST_SHIFT;
                    strobe_d = 1'b1;
                end else begin
                    sr_d      = load_word;
                    bit_idx_d = 4'd0;
                end
            end
            ST_SHIFT, ST_DONE: begin
                // A latch rise takes priority over a coincident shift.
                if (latch_rise) begin
                    state_d   = ST_LOAD;
                    sr_d      = load_word;
                    bit_idx_d = 4'd0;
                end else if (nes_rise) begin
                    sr_d = {1'b1, sr_q[7:1]};
                    if (bit_idx_q < 4'd8) begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                    if (bit_idx_q >= 4'd7) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: begin
                state_d = ST_SHIFT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_SHIFT;
            sr_q       <= 8'hFF;
            bit_idx_q  <= 4'd0;
            strobe_q   <= 1'b0;
            lvl_prev_q <= '0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            bit_idx_q  <= bit_idx_d;
            strobe_q   <= strobe_d;
            lvl_prev_q <= lvl_prev_d;
        end
    end

    assign data         = sr_q[0];
    assign frame_strobe = strobe_q;
    assign bit_idx      = bit_idx_q;
endmodule
